// File: rtl/neuron_mac_if.sv
// neuron_mac_if: handshake/data bundle between the MAC producer and neuron_mac.
//   master : drives start/bias and the pixel/weight stream (in_valid, pixel, weight)
//   slave  : neuron_mac; drives in_ready, acc_out, neuron_rdy, plane_rdy, busy
interface neuron_mac_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [DATA_W-1:0] bias;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pixel;
    logic [DATA_W-1:0] weight;
    logic [DATA_W-1:0] acc_out;
    logic              neuron_rdy;
    logic              plane_rdy;
    logic              busy;

    modport master (
        output start, bias, in_valid, pixel, weight,
        input  in_ready, acc_out, neuron_rdy, plane_rdy, busy
    );

    modport slave (
        input  start, bias, in_valid, pixel, weight,
        output in_ready, acc_out, neuron_rdy, plane_rdy, busy
    );
endinterface

// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate stage.
//   Accepts KERNEL_LEN signed Q8.8 pixel/weight pairs per neuron, accumulates the
//   Q16.16 products in a Q24.16 accumulator, adds the plane bias, rounds half up
//   and saturates to 16 bits. Each result is presented on acc_out with a one-cycle
//   neuron_rdy strobe; after NEURONS_PER_PLANE neurons a one-cycle plane_rdy follows.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   bus        : neuron_mac_if.slave (start/bias, in_valid/in_ready/pixel/weight,
//                acc_out, neuron_rdy, plane_rdy, busy)
module neuron_mac #(
    parameter int DATA_W            = 16,
    parameter int FRAC              = 8,
    parameter int ACC_W             = 40,
    parameter int KERNEL_LEN        = 9,
    parameter int NEURONS_PER_PLANE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    neuron_mac_if.slave  bus
);
    localparam int PW     = 2 * DATA_W;
    localparam int STAGES = 1;
    localparam int SC_W   = $clog2(KERNEL_LEN + 1);
    localparam int NC_W   = $clog2(NEURONS_PER_PLANE + 1);

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (FRAC - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (DATA_W - 1)));

    typedef enum logic [2:0] {IDLE, ACC, DRAIN, EMIT, PLANE} state_t;

    typedef struct packed {
        logic signed [DATA_W-1:0] pixel;
        logic signed [DATA_W-1:0] weight;
    } pair_t;

    state_t                   state, state_nx;
    pair_t                    op;
    logic signed [PW-1:0]     prod;
    logic        [STAGES:0]   vld_pipe;   // [0]: operands held, [1]: product held
    logic signed [ACC_W-1:0]  acc;
    logic        [DATA_W-1:0] bias_q;
    logic        [SC_W-1:0]   smp_cnt;
    logic        [NC_W-1:0]   nrn_cnt;
    logic        [DATA_W-1:0] acc_out_q;
    logic                     neuron_rdy_q;

    logic                     accept;
    logic                     last_smp;
    logic                     last_nrn;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  rnd_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic        [DATA_W-1:0] result;

    assign accept   = bus.in_valid && (state == ACC);
    assign last_smp = (smp_cnt == SC_W'(KERNEL_LEN - 1));
    assign last_nrn = (nrn_cnt == NC_W'(NEURONS_PER_PLANE - 1));

    // Bias is Q8.8; aligning it to the accumulator's Q.16 point.
    assign bias_ext = {{(ACC_W-DATA_W-FRAC){bias_q[DATA_W-1]}}, bias_q, {FRAC{1'b0}}};
    assign rnd_sum  = acc + bias_ext + RND;
    assign shifted  = rnd_sum >>> FRAC;

    always_comb begin
        result = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (bus.start) state_nx = ACC;
            ACC:   if (accept && last_smp) state_nx = DRAIN;
            // Leave once only the product stage is occupied; it lands in acc on
            // the same edge that moves us into EMIT.
            DRAIN: if (!vld_pipe[0]) state_nx = EMIT;
            EMIT:  state_nx = last_nrn ? PLANE : ACC;
            // First PLANE cycle carries the final neuron_rdy; plane_rdy goes in
            // the second so the two strobes never coincide.
            PLANE: if (!neuron_rdy_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            op           <= '0;
            prod         <= '0;
            vld_pipe     <= '0;
            acc          <= '0;
            bias_q       <= '0;
            smp_cnt      <= '0;
            nrn_cnt      <= '0;
            acc_out_q    <= '0;
            neuron_rdy_q <= 1'b0;
        end else begin
            state        <= state_nx;
            vld_pipe     <= {vld_pipe[STAGES-1:0], accept};
            neuron_rdy_q <= 1'b0;

            if (accept) begin
                op.pixel  <= bus.pixel;
                op.weight <= bus.weight;
                smp_cnt   <= smp_cnt + 1'b1;
            end
            if (vld_pipe[0]) prod <= PW'(op.pixel) * PW'(op.weight);
            if (vld_pipe[1]) acc  <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

            unique case (state)
                IDLE: if (bus.start) begin
                    bias_q  <= bus.bias;
                    acc     <= '0;
                    smp_cnt <= '0;
                    nrn_cnt <= '0;
                end
                EMIT: begin
                    acc_out_q    <= result;
                    neuron_rdy_q <= 1'b1;
                    acc          <= '0;
                    smp_cnt      <= '0;
                    nrn_cnt      <= nrn_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state == ACC);
    assign bus.acc_out    = acc_out_q;
    assign bus.neuron_rdy = neuron_rdy_q;
    assign bus.plane_rdy  = (state == PLANE) && !neuron_rdy_q;
    assign bus.busy       = (state != IDLE);
endmodule
